// File: rtl/game_pkg.sv
// Shared types and constants for the frame-synchronous game controller.
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [11:0] SCORE_MAX = 12'h999;

    // Most significant differing digit decides; valid BCD only.
    function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
        logic gt;
        gt = 1'b0;
        if (a[11:8] != b[11:8]) begin
            gt = (a[11:8] > b[11:8]);
        end else if (a[7:4] != b[7:4]) begin
            gt = (a[7:4] > b[7:4]);
        end else begin
            gt = (a[3:0] > b[3:0]);
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear, saturating at 999.
module bcd_counter3
    import game_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [11:0] count_o
);

    logic [11:0] count_q, count_d;
    bcd_digit_t  units, tens, hundreds;

    always_comb begin
        count_d  = count_q;
        units    = count_q[3:0];
        tens     = count_q[7:4];
        hundreds = count_q[11:8];
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != SCORE_MAX)) begin
            if (units == 4'd9) begin
                units = 4'd0;
                if (tens == 4'd9) begin
                    tens     = 4'd0;
                    hundreds = hundreds + 4'd1;
                end else begin
                    tens = tens + 4'd1;
                end
            end else begin
                units = units + 4'd1;
            end
            count_d = {hundreds, tens, units};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game state controller: MENU/PLAY/OVER changing only on frame_tick, plus flap/reset/score.
// Define FLAPPY_HISCORE_EN to add the hiscore_o and new_record_o outputs.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned OVER_HOLD_FRAMES = 60,
    parameter int unsigned HOLD_W           = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_tick_i,
    input  logic        btn_i,
    input  logic        collision_i,
    input  logic        point_i,
    output logic [1:0]  state_o,
    output logic        flap_o,
    output logic        game_rst_o,
    output logic [11:0] score_o
`ifdef FLAPPY_HISCORE_EN
    ,
    output logic [11:0] hiscore_o,
    output logic        new_record_o
`endif
);

    game_state_t       state_q, state_d;
    logic              btn_q;
    logic              start_req_q, start_req_d;
    logic              over_req_q, over_req_d;
    logic              exit_req_q, exit_req_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              flap_q, flap_d;
    logic              btn_rise;
    logic              score_inc;

    assign btn_rise = btn_i & ~btn_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= MENU;
            btn_q       <= 1'b0;
            start_req_q <= 1'b0;
            over_req_q  <= 1'b0;
            exit_req_q  <= 1'b0;
            hold_q      <= '0;
            flap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_i;
            start_req_q <= start_req_d;
            over_req_q  <= over_req_d;
            exit_req_q  <= exit_req_d;
            hold_q      <= hold_d;
            flap_q      <= flap_d;
        end
    end

    // A request seen on a frame_tick cycle is latched for the following tick.
    always_comb begin
        state_d     = state_q;
        start_req_d = start_req_q;
        over_req_d  = over_req_q;
        exit_req_d  = exit_req_q;
        hold_d      = hold_q;
        case (state_q)
            MENU: begin
                if (frame_tick_i && start_req_q) begin
                    state_d     = PLAY;
                    start_req_d = 1'b0;
                end else if (btn_rise) begin
                    start_req_d = 1'b1;
                end
            end
            PLAY: begin
                if (frame_tick_i && over_req_q) begin
                    state_d    = OVER;
                    over_req_d = 1'b0;
                    hold_d     = HOLD_W'(OVER_HOLD_FRAMES);
                end else if (collision_i) begin
                    over_req_d = 1'b1;
                end
            end
            OVER: begin
                if (frame_tick_i && (hold_q != '0)) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
                if (frame_tick_i && exit_req_q) begin
                    state_d    = MENU;
                    exit_req_d = 1'b0;
                end else if (btn_rise && (hold_q == '0)) begin
                    exit_req_d = 1'b1;
                end
            end
            default: begin
                state_d     = MENU;
                start_req_d = 1'b0;
                over_req_d  = 1'b0;
                exit_req_d  = 1'b0;
                hold_d      = '0;
            end
        endcase
    end

    // A pending or coincident collision suppresses both flap and scoring.
    always_comb begin
        game_rst_o = (state_q == MENU) && frame_tick_i && start_req_q;
        flap_d     = (state_q == PLAY) && btn_rise && !over_req_q && !collision_i;
        score_inc  = (state_q == PLAY) && point_i && !over_req_q && !collision_i;
    end

    assign state_o = state_q;
    assign flap_o  = flap_q;

    bcd_counter3 u_score (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (game_rst_o),
        .inc_i   (score_inc),
        .count_o (score_o)
    );

`ifdef FLAPPY_HISCORE_EN
    logic [11:0] hiscore_q, hiscore_d;
    logic        new_record_q, new_record_d;

    always_comb begin
        hiscore_d    = hiscore_q;
        new_record_d = new_record_q;
        if ((state_q == PLAY) && (state_d == OVER)) begin
            new_record_d = bcd_gt(score_o, hiscore_q);
            if (new_record_d) begin
                hiscore_d = score_o;
            end
        end else if (state_d != OVER) begin
            new_record_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hiscore_q    <= '0;
            new_record_q <= 1'b0;
        end else begin
            hiscore_q    <= hiscore_d;
            new_record_q <= new_record_d;
        end
    end

    assign hiscore_o    = hiscore_q;
    assign new_record_o = new_record_q;
`endif

endmodule
